// File: rtl/mult8x8_sequencer.sv
// Control FSM for an 8x8 sequential multiplier built from four 4x4 partial products.
// Drives nibble/shift selects and accumulator control; reports progress as a 3-bit state code.
`timescale 1ns/1ps
module mult8x8_sequencer #(
    parameter bit ERR_ON_RESTART = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    output logic [1:0] input_sel,
    output logic [1:0] shift_sel,
    output logic       accum_en,
    output logic       accum_clr,
    output logic [2:0] state_out,
    output logic       busy,
    output logic       done_flag,
    output logic       err_flag
);

    typedef enum logic [2:0] {
        S_IDLE = 3'b000,
        S_LSB  = 3'b001,
        S_MID  = 3'b010,
        S_MSB  = 3'b011,
        S_DONE = 3'b100,
        S_ERR  = 3'b101
    } state_t;

    state_t     state_reg, state_next;
    logic [1:0] count_reg, count_next;
    logic       start_q_reg;

    logic [1:0] input_sel_reg, input_sel_next;
    logic [1:0] shift_sel_reg, shift_sel_next;
    logic       accum_en_reg, accum_en_next;
    logic       busy_reg, busy_next;
    logic       done_reg, done_next;
    logic       err_reg, err_next;

    logic       start_pulse;
    logic       in_run;

    // Gated by reset_n so accum_clr stays low while reset is held.
    assign start_pulse = start & ~start_q_reg & reset_n;
    assign in_run      = (state_reg == S_LSB) || (state_reg == S_MID) || (state_reg == S_MSB);
    assign accum_clr   = start_pulse && (!in_run || !ERR_ON_RESTART);

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        if (in_run && start_pulse) begin
            state_next = ERR_ON_RESTART ? S_ERR : S_LSB;
            count_next = 2'd0;
        end else begin
            case (state_reg)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start_pulse) begin
                        state_next = S_LSB;
                        count_next = 2'd0;
                    end
                end
                S_LSB: begin
                    state_next = S_MID;
                    count_next = 2'd1;
                end
                S_MID: begin
                    if (count_reg == 2'd1) begin
                        state_next = S_MID;
                        count_next = 2'd2;
                    end else begin
                        state_next = S_MSB;
                        count_next = 2'd3;
                    end
                end
                S_MSB: begin
                    state_next = S_DONE;
                    count_next = 2'd0;
                end
                default: begin
                    state_next = S_IDLE;
                    count_next = 2'd0;
                end
            endcase
        end
    end

    // Moore outputs are decoded from the next state so they appear registered alongside it.
    always_comb begin
        input_sel_next = 2'b00;
        shift_sel_next = 2'b00;
        accum_en_next  = 1'b0;
        busy_next      = 1'b0;
        done_next      = 1'b0;
        err_next       = 1'b0;
        case (state_next)
            S_LSB: begin
                accum_en_next = 1'b1;
                busy_next     = 1'b1;
            end
            S_MID: begin
                input_sel_next = (count_next == 2'd1) ? 2'b01 : 2'b10;
                shift_sel_next = 2'b01;
                accum_en_next  = 1'b1;
                busy_next      = 1'b1;
            end
            S_MSB: begin
                input_sel_next = 2'b11;
                shift_sel_next = 2'b10;
                accum_en_next  = 1'b1;
                busy_next      = 1'b1;
            end
            S_DONE:  done_next = 1'b1;
            S_ERR:   err_next  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= S_IDLE;
            count_reg     <= 2'd0;
            start_q_reg   <= 1'b0;
            input_sel_reg <= 2'b00;
            shift_sel_reg <= 2'b00;
            accum_en_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            start_q_reg   <= start;
            input_sel_reg <= input_sel_next;
            shift_sel_reg <= shift_sel_next;
            accum_en_reg  <= accum_en_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            err_reg       <= err_next;
        end
    end

    assign input_sel = input_sel_reg;
    assign shift_sel = shift_sel_reg;
    assign accum_en  = accum_en_reg;
    assign state_out = state_reg;
    assign busy      = busy_reg;
    assign done_flag = done_reg;
    assign err_flag  = err_reg;

endmodule

// File: tb/tb_mult8x8_sequencer.sv
// Directed bench for mult8x8_sequencer: two instances (error-on-restart and restart mode),
// each driving a small accumulator/partial-product model of the multiplier datapath.
`timescale 1ns/1ps
module tb_mult8x8_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests    = 0;
    int failures = 0;

    // Instance with ERR_ON_RESTART = 1
    logic       rstn_e, start_e;
    logic [1:0] isel_e, ssel_e;
    logic       en_e, clr_e, busy_e, done_e, err_e;
    logic [2:0] st_e;
    // Instance with ERR_ON_RESTART = 0
    logic       rstn_r, start_r;
    logic [1:0] isel_r, ssel_r;
    logic       en_r, clr_r, busy_r, done_r, err_r;
    logic [2:0] st_r;

    mult8x8_sequencer #(.ERR_ON_RESTART(1'b1)) dut_e (
        .clk(clk), .reset_n(rstn_e), .start(start_e),
        .input_sel(isel_e), .shift_sel(ssel_e), .accum_en(en_e), .accum_clr(clr_e),
        .state_out(st_e), .busy(busy_e), .done_flag(done_e), .err_flag(err_e)
    );

    mult8x8_sequencer #(.ERR_ON_RESTART(1'b0)) dut_r (
        .clk(clk), .reset_n(rstn_r), .start(start_r),
        .input_sel(isel_r), .shift_sel(ssel_r), .accum_en(en_r), .accum_clr(clr_r),
        .state_out(st_r), .busy(busy_r), .done_flag(done_r), .err_flag(err_r)
    );

    // Datapath model: controls snapshotted mid-cycle, applied at the rising edge; clear wins.
    logic [7:0]  a_e = '0, b_e = '0, a_r = '0, b_r = '0;
    logic [15:0] acc_e = '0, acc_r = '0;
    logic        s_en_e = 0, s_clr_e = 0, s_en_r = 0, s_clr_r = 0;
    logic [1:0]  s_isel_e = 0, s_ssel_e = 0, s_isel_r = 0, s_ssel_r = 0;

    function automatic logic [15:0] pp_term(input logic [7:0] a, input logic [7:0] b,
                                            input logic [1:0] isel, input logic [1:0] ssel);
        logic [3:0]  an, bn;
        logic [15:0] p;
        an = isel[1] ? a[7:4] : a[3:0];
        bn = isel[0] ? b[7:4] : b[3:0];
        p  = 16'(an) * 16'(bn);
        case (ssel)
            2'b00:   return p;
            2'b01:   return p << 4;
            2'b10:   return p << 8;
            default: return 16'h0000;
        endcase
    endfunction

    always @(negedge clk) begin
        s_en_e = en_e; s_clr_e = clr_e; s_isel_e = isel_e; s_ssel_e = ssel_e;
        s_en_r = en_r; s_clr_r = clr_r; s_isel_r = isel_r; s_ssel_r = ssel_r;
    end

    always @(posedge clk) begin
        if (s_clr_e)     acc_e <= 16'h0000;
        else if (s_en_e) acc_e <= acc_e + pp_term(a_e, b_e, s_isel_e, s_ssel_e);
        if (s_clr_r)     acc_r <= 16'h0000;
        else if (s_en_r) acc_r <= acc_r + pp_term(a_r, b_r, s_isel_r, s_ssel_r);
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    int  lsb_seen;
    logic saw_err;

    initial begin
        rstn_e = 0; rstn_r = 0; start_e = 0; start_r = 0;
        tick; tick;
        // Reset state, including accum_clr held low with start high
        start_e = 1; #1;
        check("rst_state", 16'(st_e), 16'h0);
        check("rst_busy", 16'(busy_e), 16'h0);
        check("rst_en", 16'(en_e), 16'h0);
        check("rst_clr", 16'(clr_e), 16'h0);
        start_e = 0;
        tick;
        rstn_e = 1; rstn_r = 1;
        tick; tick;
        check("idle_hold", 16'(st_e), 16'h0);

        // Nominal FF x FF
        a_e = 8'hFF; b_e = 8'hFF;
        start_e = 1; #1;
        check("nom_clr_pre", 16'(clr_e), 16'h1);
        check("nom_en_pre", 16'(en_e), 16'h0);
        tick;
        check("nom_lsb_state", 16'(st_e), 16'h1);
        check("nom_lsb_sel", 16'({isel_e, ssel_e}), 16'b0000);
        check("nom_lsb_clr", 16'(clr_e), 16'h0);
        check("nom_lsb_en", 16'(en_e), 16'h1);
        start_e = 0;
        tick;
        check("nom_mid1_state", 16'(st_e), 16'h2);
        check("nom_mid1_sel", 16'({isel_e, ssel_e}), 16'b0101);
        tick;
        check("nom_mid2_state", 16'(st_e), 16'h2);
        check("nom_mid2_sel", 16'({isel_e, ssel_e}), 16'b1001);
        tick;
        check("nom_msb_state", 16'(st_e), 16'h3);
        check("nom_msb_sel", 16'({isel_e, ssel_e}), 16'b1110);
        tick;
        check("nom_done_state", 16'(st_e), 16'h4);
        check("nom_done_flag", 16'(done_e), 16'h1);
        check("nom_done_busy", 16'(busy_e), 16'h0);
        check("nom_product", acc_e, 16'hFE01);

        // Back-to-back 12 x 34 from DONE
        a_e = 8'h12; b_e = 8'h34;
        start_e = 1; #1;
        check("b2b_clr", 16'(clr_e), 16'h1);
        check("b2b_done_still", 16'(done_e), 16'h1);
        tick;
        check("b2b_lsb", 16'(st_e), 16'h1);
        check("b2b_done_drop", 16'(done_e), 16'h0);
        check("b2b_acc_cleared", acc_e, 16'h0000);
        start_e = 0;
        tick; tick; tick; tick;
        check("b2b_done", 16'(st_e), 16'h4);
        check("b2b_product", acc_e, 16'h03A8);

        // Held start for 20 cycles: exactly one run
        start_e = 1;
        lsb_seen = 0; saw_err = 0;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (st_e == 3'b001) lsb_seen++;
            if (err_e) saw_err = 1;
        end
        check("held_runs", 16'(lsb_seen), 16'h1);
        check("held_done", 16'(st_e), 16'h4);
        check("held_no_err", 16'(saw_err), 16'h0);
        start_e = 0;
        tick;

        // Restart during MID count 1 -> ERR
        start_e = 1; tick;
        start_e = 0; tick;
        check("err_mid1_sel", 16'(isel_e), 16'b01);
        start_e = 1; #1;
        check("err_no_clr", 16'(clr_e), 16'h0);
        tick;
        check("err_state", 16'(st_e), 16'h5);
        check("err_flag", 16'(err_e), 16'h1);
        check("err_en", 16'(en_e), 16'h0);
        check("err_busy", 16'(busy_e), 16'h0);
        start_e = 0; tick;
        check("err_hold", 16'(st_e), 16'h5);
        start_e = 1; #1;
        check("err_exit_clr", 16'(clr_e), 16'h1);
        tick;
        check("err_exit_lsb", 16'(st_e), 16'h1);
        check("err_exit_acc", acc_e, 16'h0000);
        start_e = 0;
        tick; tick; tick; tick;
        check("err_rerun_product", acc_e, 16'h03A8);

        // Asynchronous reset in MID count 2
        start_e = 1; tick;
        start_e = 0; tick; tick;
        check("ar_mid2_sel", 16'(isel_e), 16'b10);
        #2 rstn_e = 0;
        #1;
        check("ar_state", 16'(st_e), 16'h0);
        check("ar_sel", 16'({isel_e, ssel_e}), 16'h0);
        check("ar_en_busy", 16'({en_e, busy_e, done_e, err_e, clr_e}), 16'h0);
        tick;
        rstn_e = 1;
        tick; tick;
        check("ar_idle_after", 16'(st_e), 16'h0);

        // Restart mode instance: 0F x F0 with a restart in MID count 1
        a_r = 8'h0F; b_r = 8'hF0;
        start_r = 1; tick;
        start_r = 0; tick;
        check("rs_mid1", 16'(st_r), 16'h2);
        start_r = 1; #1;
        check("rs_clr", 16'(clr_r), 16'h1);
        check("rs_en_with_clr", 16'(en_r), 16'h1);
        tick;
        check("rs_lsb", 16'(st_r), 16'h1);
        check("rs_lsb_sel", 16'(isel_r), 16'b00);
        check("rs_acc_cleared", acc_r, 16'h0000);
        start_r = 0;
        tick; tick; tick; tick;
        check("rs_done", 16'(done_r), 16'h1);
        check("rs_product", acc_r, 16'h0E10);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
